cla_sub_64bit_pipe: RTL
=======================

CLA_SUB_64BIT_PIPE -- requirements
Module: cla_sub_64bit_pipe

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 64 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand beat valid.
REQ-005 in_ready  output  1  block can accept an operand beat this cycle.
REQ-006 a  input  64  minuend, unsigned or two's complement.
REQ-007 b  input  64  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result beat valid.
REQ-010 out_ready  input  1  downstream accepts the result beat.
REQ-011 diff  output  64  a - b - bin, modulo 2^64.
REQ-012 bout  output  1  borrow-out; 1 when a < b + bin, unsigned.
REQ-013 zero, neg, ovf  output  1 each  result flags; present only under CLA_SUB_FLAGS_EN.

Function
REQ-014 A beat SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready, both at the rising edge.
REQ-015 Arithmetic SHALL be a + ~b + ~bin; bout SHALL equal the inverted final carry.
REQ-016 Stage 1 SHALL register per-bit p = a ^ ~b and g = a & ~b, the 16 four-bit group G/P terms, the four 16-bit section G/P terms and carry-in ~bin.
REQ-017 Stage 2 SHALL use the registered terms to compute section carries, group carries, bit carries, diff and bout. It SHALL register these into the output stage.
REQ-018 Stage 2 SHALL NOT ripple carries across 4-bit group boundaries.
REQ-019 Latency SHALL be 2 cycles: a beat accepted at edge N SHALL be presented with out_valid=1 after edge N+1.
REQ-020 With out_ready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-021 Stage 1 SHALL advance when stage 2 is empty or stage 2 is being consumed.
REQ-022 in_ready SHALL be !s1_valid || s1_advance; a combinational path from out_ready to in_ready is permitted.
REQ-023 When out_valid=1 and out_ready=0, diff, bout, flags and out_valid SHALL hold stable until the transfer.
REQ-024 Under backpressure the block SHALL hold at most 2 beats, one per stage. In that state in_ready SHALL be 0 and no beat SHALL be dropped or duplicated.
REQ-025 Beats SHALL leave in acceptance order.
REQ-026 Input signals other than in_valid SHALL be ignored in cycles with in_valid=0.
REQ-027 A simultaneous output transfer and input acceptance SHALL both complete in the same cycle.

Reset
REQ-028 While rst=1, s1_valid, out_valid, diff, bout, zero, neg and ovf SHALL be 0 at the next edge; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight beats; no discarded beat SHALL appear after reset.

Configuration
REQ-030 With macro CLA_SUB_FLAGS_EN defined, the block SHALL provide three flags registered alongside diff:
- zero = (diff == 0)
- neg = diff[63]
- ovf = (a[63] != b[63]) && (diff[63] != a[63])
REQ-031 Without CLA_SUB_FLAGS_EN, ports zero, neg and ovf and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-032 a=5, b=3, bin=0, out_ready=1 -> two cycles later: out_valid=1, diff=2, bout=0, zero=0, neg=0, ovf=0.
REQ-033 a=0, b=1, bin=0 -> diff=0xFFFFFFFFFFFFFFFF, bout=1, neg=1, ovf=0; a=b=0x123456789ABCDEF0, bin=1 -> diff=0xFFFFFFFFFFFFFFFF, bout=1.
REQ-034 a=0x8000000000000000, b=1, bin=0 -> diff=0x7FFFFFFFFFFFFFFF, bout=0, ovf=1; a=7, b=7, bin=0 -> diff=0, zero=1, bout=0.
REQ-035 Backpressure: 3 back-to-back beats (1-1, 10-4, 0-0), out_ready=0 for 5 cycles:
- in_ready drops after 2 beats are accepted and the third beat stalls;
- outputs stay stable while stalled;
- on release, results 0, 6, 0 appear in order, one per cycle.
REQ-036 Stream of 1000 random beats with random in_valid/out_ready -> every diff/bout matches the reference model, in order, with no loss.
REQ-037 rst pulsed for 1 cycle while 2 beats are in flight -> out_valid=0 after the reset edge; the discarded results never appear, and the next accepted beat emerges with 2-cycle latency.

Source files
------------

// File: rtl/cla_sub_64bit_pipe.sv
// Two-stage pipelined 64-bit carry-lookahead subtractor: diff = a - b - bin, bout = borrow-out.
// Define CLA_SUB_FLAGS_EN to add registered zero/neg/ovf result flags.
module cla_sub_64bit_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        bin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] diff,
   output logic        bout
`ifdef CLA_SUB_FLAGS_EN
   ,
   output logic        zero,
   output logic        neg,
   output logic        ovf
`endif
);

   // Handshake: a beat moves on any rising edge where valid && ready; a producer
   // holds valid and payload until that edge, and ready may depend on out_ready.

   // Generate of a 4-wide block; p[0] only matters for the block propagate.
   function automatic logic grp_gen(input logic [3:0] g, input logic [3:1] p);
      grp_gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   // Carries into positions 1..3 of a 4-wide block, fully expanded (no ripple).
   function automatic logic [2:0] carries3(input logic [2:0] g, input logic [2:0] p,
                                           input logic c);
      logic c1, c2, c3;
      c1 = g[0] | (p[0] & c);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      carries3 = {c3, c2, c1};
   endfunction

   // ---------------- stage 1: propagate/generate terms ----------------
   logic [63:0] p_c, g_c;
   logic [15:0] gg_c, gp_c;
   logic [3:0]  sg_c, sp_c;

   assign p_c = a ^ ~b;
   assign g_c = a & ~b;

   always_comb begin
      gg_c = '0;
      gp_c = '0;
      for (int i = 0; i < 16; i++) begin
         gg_c[i] = grp_gen(g_c[4*i +: 4], p_c[4*i+1 +: 3]);
         gp_c[i] = &p_c[4*i +: 4];
      end
   end

   always_comb begin
      sg_c = '0;
      sp_c = '0;
      for (int k = 0; k < 4; k++) begin
         sg_c[k] = grp_gen(gg_c[4*k +: 4], gp_c[4*k+1 +: 3]);
         sp_c[k] = &gp_c[4*k +: 4];
      end
   end

   logic        s1_valid;
   logic [63:0] s1_p, s1_g;
   logic [15:0] s1_gg, s1_gp;
   logic [3:0]  s1_sg, s1_sp;
   logic        s1_cin;

   logic load_out;
   assign load_out = !out_valid || out_ready;
   assign in_ready = !s1_valid || load_out;

   // Payload registers only load on an accepted beat, so idle inputs are ignored.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         s1_p   <= p_c;
         s1_g   <= g_c;
         s1_gg  <= gg_c;
         s1_gp  <= gp_c;
         s1_sg  <= sg_c;
         s1_sp  <= sp_c;
         s1_cin <= ~bin;
      end
   end

   // ---------------- stage 2: carries and result ----------------
   logic [4:0]  sec_c;
   logic [15:0] grp_c;
   logic [64:0] bit_c;

   always_comb begin
      sec_c      = '0;
      sec_c[0]   = s1_cin;
      sec_c[3:1] = carries3(s1_sg[2:0], s1_sp[2:0], s1_cin);
      sec_c[4]   = grp_gen(s1_sg, s1_sp[3:1]) | ((&s1_sp) & s1_cin);
   end

   always_comb begin
      grp_c = '0;
      for (int k = 0; k < 4; k++) begin
         grp_c[4*k]        = sec_c[k];
         grp_c[4*k+1 +: 3] = carries3(s1_gg[4*k +: 3], s1_gp[4*k +: 3], sec_c[k]);
      end
   end

   // Each group starts from its lookahead carry, never from its neighbour's bit 3.
   always_comb begin
      bit_c = '0;
      for (int i = 0; i < 16; i++) begin
         bit_c[4*i]        = grp_c[i];
         bit_c[4*i+1 +: 3] = carries3(s1_g[4*i +: 3], s1_p[4*i +: 3], grp_c[i]);
      end
      bit_c[64] = sec_c[4];
   end

   logic [63:0] diff_c;
   logic        bout_c;
   assign diff_c = s1_p ^ bit_c[63:0];
   assign bout_c = ~bit_c[64];

   // The top terms of every group/section are folded into higher levels instead.
   logic unused_terms;
   assign unused_terms = ^{s1_gg, s1_gp, s1_g};

`ifdef CLA_SUB_FLAGS_EN
   logic zero_c, neg_c, ovf_c;
   assign zero_c = (diff_c == 64'd0);
   assign neg_c  = diff_c[63];
   // p[63]==0 means a[63]!=b[63]; then g[63] equals a[63].
   assign ovf_c  = ~s1_p[63] & (diff_c[63] ^ s1_g[63]);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         diff      <= 64'd0;
         bout      <= 1'b0;
`ifdef CLA_SUB_FLAGS_EN
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (load_out) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               diff <= diff_c;
               bout <= bout_c;
`ifdef CLA_SUB_FLAGS_EN
               zero <= zero_c;
               neg  <= neg_c;
               ovf  <= ovf_c;
`endif
            end
         end
      end
   end

endmodule
